io_bus_initiator: RTL and testbench

- Alternative initiator on the MicroBlaze MCS IO bus. It drives IO_addr_strobe, IO_read_strobe and IO_write_strobe exactly as the MCS core does, so the FPro bridge and MMIO fabric behind it run unchanged.
- It accepts single read/write commands on a valid/ready stream, issues one IO bus transaction per command, and waits for io_ready.
- Each command returns one response carrying read data or a timeout flag.
- Used by debug/DMA agents in place of, or muxed with, the CPU.

---
 rtl/io_bus_pkg.sv | 23 ++
 rtl/io_bus_initiator_if.sv | 49 ++++
 rtl/io_bus_initiator.sv | 134 +++++++++++++
 tb/tb_io_bus_initiator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types for the MCS IO bus initiator: FSM states, command record, read byte-enable.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } io_cmd_t;

    // Reads always fetch the whole word; the byte lanes are selected by the requester.
    localparam logic [3:0] RD_BE_ALL = 4'hF;

endpackage

// File: rtl/io_bus_initiator_if.sv
// Command/response stream plus MicroBlaze MCS IO bus signals of one initiator.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; io_ready completes a bus cycle.
// Modports: master = the initiator (drives cmd_ready, rsp_*, io_* strobes/address/data),
//           slave  = its environment (command source, response sink and IO fabric).
interface io_bus_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;

    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [31:0] io_address;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_timeout,
        input  rsp_ready,
        output io_addr_strobe, io_read_strobe, io_write_strobe,
        output io_address, io_byte_enable, io_write_data,
        input  io_read_data, io_ready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_timeout,
        output rsp_ready,
        input  io_addr_strobe, io_read_strobe, io_write_strobe,
        input  io_address, io_byte_enable, io_write_data,
        output io_read_data, io_ready
    );

endinterface

// File: rtl/io_bus_initiator.sv
// Issues one MCS IO bus read/write per accepted command and returns one response (data or timeout).
// Latency: strobe the cycle after accept; response the cycle after io_ready is sampled (min 3 cycles accept-to-response).
// Backpressure: one transaction in flight; cmd_ready only in IDLE; response held stable until rsp_ready.
// Ports: clk, reset (async, active-high), bus (master modport: cmd stream in, rsp stream out, IO bus).
module io_bus_initiator
    import io_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    io_bus_initiator_if.master   bus
);

    // Last WAIT cycle: counter starts at 0, so the value TIMEOUT_CYCLES-1 marks WAIT cycle number TIMEOUT_CYCLES.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    io_cmd_t              cmd_in;
    state_t               state_q,  state_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic                 write_q,  write_d;
    logic                 addr_stb_q, addr_stb_d;
    logic                 rd_stb_q,   rd_stb_d;
    logic                 wr_stb_q,   wr_stb_d;
    logic [31:0]          address_q,  address_d;
    logic [3:0]           be_q,       be_d;
    logic [31:0]          wdata_q,    wdata_d;
    logic                 rsp_vld_q,  rsp_vld_d;
    logic [31:0]          rdata_q,    rdata_d;
    logic                 tmo_q,      tmo_d;

    assign cmd_in = '{write: bus.cmd_write, addr: bus.cmd_addr,
                      wdata: bus.cmd_wdata, be: bus.cmd_be};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_stb_d = 1'b0;
        rd_stb_d   = 1'b0;
        wr_stb_d   = 1'b0;
        address_d  = address_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rsp_vld_d  = rsp_vld_q;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;

        case (state_q)
            IDLE: begin
                // Bus fields are loaded at accept so the strobes line up with the STROBE state.
                if (bus.cmd_valid) begin
                    state_d    = STROBE;
                    write_d    = cmd_in.write;
                    addr_stb_d = 1'b1;
                    rd_stb_d   = !cmd_in.write;
                    wr_stb_d   = cmd_in.write;
                    address_d  = cmd_in.addr;
                    be_d       = cmd_in.write ? cmd_in.be : RD_BE_ALL;
                    wdata_d    = cmd_in.write ? cmd_in.wdata : 32'h0;
                end
            end
            STROBE: begin
                // io_ready here belongs to no transaction of ours and is ignored.
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.io_ready) begin
                    state_d   = RESP;
                    rsp_vld_d = 1'b1;
                    rdata_d   = write_q ? 32'h0 : bus.io_read_data;
                    tmo_d     = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    rsp_vld_d = 1'b1;
                    rdata_d   = 32'h0;
                    tmo_d     = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d   = IDLE;
                    rsp_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_stb_q <= 1'b0;
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            address_q  <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            rsp_vld_q  <= 1'b0;
            rdata_q    <= 32'h0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_stb_q <= addr_stb_d;
            rd_stb_q   <= rd_stb_d;
            wr_stb_q   <= wr_stb_d;
            address_q  <= address_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rsp_vld_q  <= rsp_vld_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.cmd_ready       = (state_q == IDLE);
    assign bus.io_addr_strobe  = addr_stb_q;
    assign bus.io_read_strobe  = rd_stb_q;
    assign bus.io_write_strobe = wr_stb_q;
    assign bus.io_address      = address_q;
    assign bus.io_byte_enable  = be_q;
    assign bus.io_write_data   = wdata_q;
    assign bus.rsp_valid       = rsp_vld_q;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.rsp_timeout     = tmo_q;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Randomized and directed bench for io_bus_initiator against a transaction-level expectation model.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls with cmd_valid held high.
module tb_io_bus_initiator;

    localparam int TO = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    io_bus_initiator_if bus ();

    io_bus_initiator #(
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete command. dly = WAIT cycle (1-based) in which io_ready is raised;
    // values outside 1..TO mean the fabric never answers. hold = cycles of rsp_ready low.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int dly, input logic [31:0] rd,
                          input int hold, input logic stray);
        logic        tmo;
        int          end_k;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;

        tmo    = (dly < 1) || (dly > TO);
        end_k  = tmo ? TO : dly;
        exp_be = wr ? be : 4'hF;
        exp_wd = wr ? wdata : 32'h0;
        exp_rd = (tmo || wr) ? 32'h0 : rd;

        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_be    = be;
        tick();

        // STROBE cycle; scramble cmd_* to show they are sampled only at accept.
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_be    = 4'($urandom);
        check("addr_strobe", bus.io_addr_strobe, 1);
        check("read_strobe", bus.io_read_strobe, !wr);
        check("write_strobe", bus.io_write_strobe, wr);
        check("address", bus.io_address, addr);
        check("byte_enable", bus.io_byte_enable, exp_be);
        check("write_data", bus.io_write_data, exp_wd);
        check("cmd_ready_busy", bus.cmd_ready, 0);
        bus.io_ready     = stray;
        bus.io_read_data = $urandom;

        for (int k = 1; k <= end_k; k++) begin
            tick();
            check("wait_strobes", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 0);
            check("wait_rsp_valid", bus.rsp_valid, 0);
            check("wait_addr_hold", bus.io_address, addr);
            check("wait_be_hold", bus.io_byte_enable, exp_be);
            bus.io_ready     = (k == dly);
            bus.io_read_data = (k == dly) ? rd : $urandom;
        end
        tick();
        bus.io_ready = 1'b0;
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_timeout", bus.rsp_timeout, tmo);

        // Stall the response with a new command pending and stray io_ready noise.
        bus.rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid    = 1'b1;
            bus.io_ready     = 1'($urandom_range(0, 1));
            bus.io_read_data = $urandom;
            tick();
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rdata", bus.rsp_rdata, exp_rd);
            check("hold_timeout", bus.rsp_timeout, tmo);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            check("hold_strobe", bus.io_addr_strobe, 0);
        end
        bus.io_ready  = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("post_hs_rsp_valid", bus.rsp_valid, 0);
        check("post_hs_cmd_ready", bus.cmd_ready, 1);
        check("post_hs_strobe", bus.io_addr_strobe, 0);
    endtask

    // Idle cycles with stray io_ready pulses that must not create responses.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.io_ready     = 1'($urandom_range(0, 1));
            bus.io_read_data = $urandom;
            tick();
            check("idle_rsp_valid", bus.rsp_valid, 0);
            check("idle_cmd_ready", bus.cmd_ready, 1);
            check("idle_strobe", bus.io_addr_strobe, 0);
        end
        bus.io_ready = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset            = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_write    = 1'b0;
        bus.cmd_addr     = 32'h0;
        bus.cmd_wdata    = 32'h0;
        bus.cmd_be       = 4'h0;
        bus.rsp_ready    = 1'b0;
        bus.io_read_data = 32'h0;
        bus.io_ready     = 1'b0;

        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_strobes", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 0);
        check("rst_address", bus.io_address, 0);
        check("rst_byte_enable", bus.io_byte_enable, 0);
        check("rst_write_data", bus.io_write_data, 0);
        reset = 1'b0;
        tick();

        // Directed cases.
        do_txn(1'b1, 32'hC000_0010, 32'h1234_5678, 4'hF, 2, 32'hDEAD_BEEF, 0, 1'b0);
        do_txn(1'b0, 32'hC000_0204, 32'h5555_AAAA, 4'h3, 1, 32'hA5A5_0F0F, 0, 1'b0);
        do_txn(1'b0, 32'hC000_0300, 32'h0, 4'h1, 0, 32'h1111_2222, 0, 1'b0);
        idle_cycles(6);
        do_txn(1'b1, 32'hC000_0400, 32'hCAFE_F00D, 4'h6, 3, 32'h0, 5, 1'b0);
        do_txn(1'b0, 32'hC000_0500, 32'h0, 4'h0, 3, 32'h0BAD_C0DE, 0, 1'b1);
        do_txn(1'b0, 32'hC000_0600, 32'h0, 4'h8, TO, 32'h7777_8888, 0, 1'b0);
        idle_cycles(4);

        // Reset while the strobe is up: strobe drops without waiting for a clock edge.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'hC000_0700;
        bus.cmd_wdata = 32'h0102_0304;
        bus.cmd_be    = 4'hF;
        tick();
        bus.cmd_valid = 1'b0;
        check("pre_rst_strobe", bus.io_addr_strobe, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_strobe_async", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 0);
        check("rst_strobe_cmd_ready", bus.cmd_ready, 1);
        tick();
        reset = 1'b0;

        // Reset in WAIT, then in RESP: pending response is discarded.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'hC000_0800;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check("rst_wait_strobes", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 0);
        check("rst_wait_rsp_valid", bus.rsp_valid, 0);
        check("rst_wait_cmd_ready", bus.cmd_ready, 1);
        tick();
        reset = 1'b0;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.io_ready     = 1'b1;
        bus.io_read_data = 32'h4242_4242;
        tick();
        bus.io_ready = 1'b0;
        check("pre_rst_rsp_valid", bus.rsp_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_resp_rsp_valid", bus.rsp_valid, 0);
        check("rst_resp_rdata", bus.rsp_rdata, 0);
        check("rst_resp_cmd_ready", bus.cmd_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        do_txn(1'b0, 32'hC000_0900, 32'h0, 4'h2, 2, 32'h9876_5432, 0, 1'b0);
        idle_cycles(2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(1, TO + 3)), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
